mux_rr_arb: RTL and testbench
=============================

Name: mux_rr_arb

Overview:
- Parametrised successor to the fixed 4:1 5-bit select mux.
- Merges N W-bit source channels into one registered output stream.
- Uses round-robin arbitration and valid/ready handshakes on both sides, replacing the external select input.
- Used wherever several producers (tile generators, key scanners, score events) share one consumer such as the display or score path.

Parameters:
- W, 5, data width per channel.
- N, 4, number of input channels (2..16).
- SELW, 2, width of the channel index; must satisfy 2^SELW >= N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel k occupies bits [k*W+W-1 : k*W].
- in_valid  input  N  per-channel request/valid.
- in_ready  output  N  per-channel accept; at most one bit high.
- out_data  output  W  registered selected data.
- out_ch  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word when out_valid is also high.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - out_valid=0, out_data=0, out_ch=0.
  - Last-grant pointer = N-1, so channel 0 has first priority after reset.
  - in_ready is all zeros because it is gated by rst_n.
- can_load = !out_valid | out_ready (output register empty or being drained this cycle).
- Grant (combinational):
  - Search in_valid starting at index (ptr+1) mod N, ascending, wrapping at N-1 to 0.
  - The first set bit is channel g.
  - in_ready[g] = can_load; all other in_ready bits are 0.
  - If no in_valid bit is set, there is no grant and in_ready is all zeros.
- Transfer on a clock edge with a grant and can_load:
  - out_data <= in_data[g].
  - out_ch <= g.
  - out_valid <= 1.
  - ptr <= g.
- Drain with no grant: if out_valid & out_ready, then out_valid <= 0. out_data and out_ch hold their values.
- Latency and throughput:
  - One cycle from input handshake to out_valid.
  - Sustained throughput is one word per cycle when out_ready stays high; simultaneous drain and load in the same cycle is required.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_ch and out_valid hold.
  - in_ready is all zeros.
  - ptr holds.
- Fairness:
  - A channel holding in_valid is granted within N transfers.
  - ptr advances only on an actual transfer, never on idle cycles.
- Non-power-of-2 N: indices >= N are never granted, and the pointer wraps from N-1 to 0.
- Sources may drop or change in_valid and in_data without a handshake; only the word sampled on the accept edge matters.
- Reset mid-transfer: the pending output word is discarded, out_valid falls immediately (asynchronously), and arbitration restarts at channel 0.
- Combinational paths:
  - in_ready depends combinationally on in_valid and out_ready.
  - No path from in_data to any output except through the register.

Test Plan (W=5, N=4 unless stated):
- Reset with all in_valid=1:
  - Expect in_ready=0000 during reset.
  - First transfer after release is ch0.
  - Next cycle expect out_valid=1, out_ch=0, out_data=in_data[4:0].
- All four channels valid continuously, data k+1 on channel k, out_ready=1:
  - out_ch sequence 0,1,2,3,0,1…
  - out_data sequence 1,2,3,4,1,2…
  - out_valid never drops.
- Only ch2 valid (data 5'h1A), out_ready=1 for 3 cycles:
  - Three transfers with out_ch=2 and out_data=5'h1A.
  - Then raise ch0 and ch2 together: ch0 is granted first (ptr=2, so search starts at 3 then wraps to 0).
- Stall: load ch1 (5'h0F), hold out_ready=0 for 5 cycles with ch3 valid:
  - out_data stays 5'h0F and in_ready=0000 throughout the stall.
  - Raising out_ready gives ch3 the next word, back-to-back with no bubble.
- N=3 build, all channels valid:
  - Grant sequence 0,1,2,0.
  - out_ch never equals 3.
- Assert rst_n=0 mid-stream while out_valid=1:
  - out_valid=0 before the next clock edge.
  - After release, ch0 is granted first.

Source files
------------

// File: rtl/mux_rr_arb.sv
// Round-robin N:1 stream merger: picks one valid source per cycle into a
// registered output word with valid/ready handshakes on both sides.
module mux_rr_arb #(
    parameter int unsigned W    = 5,
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    // One extra bit so ptr + offset never overflows before the wrap subtract.
    localparam int unsigned PW = SELW + 1;

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] gnt_idx;
    logic            gnt_found;
    logic            can_load;
    logic            load;
    logic [PW-1:0]   cand;
    logic [W-1:0]    ch_data [N];

    for (genvar c = 0; c < N; c++) begin : g_unpack
        assign ch_data[c] = in_data[c*W +: W];
    end

    assign can_load = !out_valid || out_ready;
    assign load     = gnt_found && can_load;

    // Search ascending from ptr+1, wrapping at N-1, so the last winner goes last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = {1'b0, ptr} + PW'(i);
            if (cand >= PW'(N)) begin
                cand = cand - PW'(N);
            end
            if (!gnt_found && in_valid[cand[SELW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[SELW-1:0];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(N - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ch_data[gnt_idx];
            out_ch    <= gnt_idx;
            ptr       <= gnt_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: expected words are queued by the stimulus and
// compared by per-instance monitors whenever an output word is consumed.
module tb_mux_rr_arb;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [19:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [4:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [14:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [4:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int checks   = 0;
    int failures = 0;

    logic [6:0] exp_q  [$];
    logic [6:0] exp_q3 [$];

    always #5 clk = ~clk;

    mux_rr_arb #(.W(5), .N(4), .SELW(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mux_rr_arb #(.W(5), .N(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    function automatic logic [6:0] mk(input int ch, input int data);
        return {2'(ch), 5'(data)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Each word consumed (valid & ready at the next edge) is compared in order.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL n4_word unexpected actual ch=%0d data=%h", out_ch, out_data);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({out_ch, out_data} !== e) begin
                    failures++;
                    $display("FAIL n4_word actual ch=%0d data=%h expected ch=%0d data=%h",
                             out_ch, out_data, e[6:5], e[4:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid3 && out_ready3) begin
            checks++;
            if (exp_q3.size() == 0) begin
                failures++;
                $display("FAIL n3_word unexpected actual ch=%0d data=%h", out_ch3, out_data3);
            end else begin
                logic [6:0] e;
                e = exp_q3.pop_front();
                if ({out_ch3, out_data3} !== e) begin
                    failures++;
                    $display("FAIL n3_word actual ch=%0d data=%h expected ch=%0d data=%h",
                             out_ch3, out_data3, e[6:5], e[4:0]);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        in_data    = {5'd4, 5'd3, 5'd2, 5'd1};
        in_valid   = 4'b1111;
        out_ready  = 1'b1;
        in_data3   = {5'd3, 5'd2, 5'd1};
        in_valid3  = 3'b000;
        out_ready3 = 1'b0;

        // Reset state with every source requesting.
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_ch", 32'(out_ch), 32'h0);
        chk("rst_n3_out_valid", 32'(out_valid3), 32'h0);

        // Release: ch0 first, then strict rotation at one word per cycle.
        rst_n = 1'b1;
        #1;
        chk("first_grant_ch0", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 8; i++) exp_q.push_back(mk(i % 4, (i % 4) + 1));
        for (int i = 0; i < 8; i++) begin
            step();
            chk("stream_no_bubble", 32'(out_valid), 32'h1);
        end
        in_valid = 4'b0000;
        step();
        chk("drain_idle", 32'(out_valid), 32'h0);

        // Only ch2 requesting, then ch0 joins: ch0 wins after ptr=2.
        in_data  = {5'd0, 5'h1A, 5'd0, 5'h05};
        in_valid = 4'b0100;
        repeat (3) exp_q.push_back(mk(2, 5'h1A));
        repeat (3) step();
        in_valid = 4'b0101;
        #1;
        chk("wrap_grant_ch0", 32'(in_ready), 32'b0001);
        exp_q.push_back(mk(0, 5'h05));
        exp_q.push_back(mk(2, 5'h1A));
        repeat (2) step();
        in_valid = 4'b0000;
        step();

        // Stall: ch1 word held while out_ready is low, ch3 follows without a bubble.
        in_data  = {5'h13, 5'd0, 5'h0F, 5'd0};
        in_valid = 4'b0010;
        exp_q.push_back(mk(1, 5'h0F));
        step();
        out_ready = 1'b0;
        in_valid  = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'h0);
            chk("stall_data", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 2'd1, 5'h0F}));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_grant_ch3", 32'(in_ready), 32'b1000);
        exp_q.push_back(mk(3, 5'h13));
        step();
        chk("unstall_back_to_back", 32'({out_valid, out_ch}), 32'({1'b1, 2'd3}));
        in_valid = 4'b0000;
        step();

        // Reset with a word pending: discarded asynchronously, restart at ch0.
        in_data   = {5'd4, 5'd3, 5'd2, 5'd1};
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        step();
        chk("pre_reset_loaded", 32'({out_valid, out_ch}), 32'({1'b1, 2'd2}));
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'h0);
        chk("async_reset_ready", 32'(in_ready), 32'h0);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 1));
        step();
        chk("post_reset_ch0", 32'({out_valid, out_ch}), 32'({1'b1, 2'd0}));
        in_valid = 4'b0000;
        step();

        // N=3 instance: rotation 0,1,2,0,... never producing index 3.
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        for (int i = 0; i < 6; i++) exp_q3.push_back(mk(i % 3, (i % 3) + 1));
        repeat (6) step();
        in_valid3 = 3'b000;
        repeat (2) step();

        chk("n4_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("n3_queue_empty", 32'(exp_q3.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
